// File: rtl/mux_pkg.sv
// Shared encodings for the scanning N:1 selector: mode bits, FSM states and dwell counter width.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int DWELL_CW = 8;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } mux_state_t;

endpackage

// File: rtl/mux_nx1_comb.sv
// Purely combinational N:1 selector over a flat N*W bus; channel k sits at [k*W +: W].
// Zero latency, no flow control; an index with no matching channel yields zero.
module mux_nx1_comb #(
    parameter  int N  = 16,
    parameter  int W  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic [N*W-1:0] di,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   y
);

    always_comb begin
        y = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SW'(k)) begin
                y = di[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/mux_scan_nx1.sv
// Registered N:1 channel selector with manual select and round-robin scan (programmable dwell, skips invalid channels).
// Data latency one edge, select latency two edges; y/y_valid/y_sel hold and the scan freezes while y_valid && !y_ready.
module mux_scan_nx1
    import mux_pkg::*;
#(
    parameter  int N     = 16,
    parameter  int W     = 8,
    parameter  int DWELL = 4,
    localparam int SW    = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [SW-1:0]  sel_in,
    input  logic           sel_load,
    input  logic [N*W-1:0] di,
    input  logic [N-1:0]   di_valid,
    output logic [W-1:0]   y,
    output logic           y_valid,
    input  logic           y_ready,
    output logic [SW-1:0]  y_sel,
    output logic           sel_err
);

    localparam logic [SW:0]         N_LIM      = (SW+1)'(N);
    localparam logic [SW-1:0]       LAST_SEL   = SW'(N-1);
    localparam logic [DWELL_CW-1:0] DWELL_LAST = DWELL_CW'(DWELL-1);

    mux_state_t          state_q, state_d;
    logic [SW-1:0]       cur_sel_q, cur_sel_d;
    logic [DWELL_CW-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [W-1:0]        y_q, y_d;
    logic                y_valid_q, y_valid_d;
    logic [SW-1:0]       y_sel_q, y_sel_d;
    logic                sel_err_q, sel_err_d;

    logic [W-1:0]        mux_dat;
    logic [0:0]          mux_vld;
    logic                cap;
    logic                load_ok;
    logic [SW-1:0]       next_sel;
    logic [DWELL_CW-1:0] dwell_base;

    mux_nx1_comb #(.N(N), .W(W)) u_dat_mux (
        .di  (di),
        .sel (cur_sel_q),
        .y   (mux_dat)
    );

    mux_nx1_comb #(.N(N), .W(1)) u_vld_mux (
        .di  (di_valid),
        .sel (cur_sel_q),
        .y   (mux_vld)
    );

    always_comb begin
        cap        = !y_valid_q || y_ready;
        load_ok    = sel_load && ({1'b0, sel_in} < N_LIM);
        next_sel   = (cur_sel_q == LAST_SEL) ? '0 : cur_sel_q + SW'(1);
        state_d    = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
        // A fresh scan always starts its first channel with a full dwell.
        dwell_base = (state_q == ST_SCAN) ? dwell_cnt_q : '0;

        y_d       = y_q;
        y_valid_d = y_valid_q;
        y_sel_d   = y_sel_q;
        if (cap) begin
            y_d       = mux_dat;
            y_valid_d = mux_vld[0];
            y_sel_d   = cur_sel_q;
        end

        sel_err_d   = sel_load && !load_ok;
        cur_sel_d   = cur_sel_q;
        dwell_cnt_d = dwell_cnt_q;

        // Any load strobe, even a rejected one, blocks the scan from moving on this edge.
        if (load_ok) begin
            cur_sel_d   = sel_in;
            dwell_cnt_d = '0;
        end else if (state_d == ST_MANUAL) begin
            dwell_cnt_d = '0;
        end else if (!sel_load && cap) begin
            if (mux_vld[0] && (dwell_base != DWELL_LAST)) begin
                dwell_cnt_d = dwell_base + DWELL_CW'(1);
            end else begin
                cur_sel_d   = next_sel;
                dwell_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_MANUAL;
            cur_sel_q   <= '0;
            dwell_cnt_q <= '0;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            y_sel_q     <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_sel_q   <= cur_sel_d;
            dwell_cnt_q <= dwell_cnt_d;
            y_q         <= y_d;
            y_valid_q   <= y_valid_d;
            y_sel_q     <= y_sel_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign y_sel   = y_sel_q;
    assign sel_err = sel_err_q;

endmodule

// File: doc/mux_scan_nx1.md
# mux_scan_nx1

Parametrised N-channel, W-bit registered multiplexer with manual and auto-scan modes. It generalises the fixed 16:1 single-bit combinational mux into a clocked selector for the datapath. Its output is presented through a valid/ready handshake. In scan mode it round-robins across the channels with a programmable dwell and skips channels whose input is not valid.

## Interface
- `N`, default 16: number of input channels, 2..256.
- `W`, default 8: data width per channel.
- `DWELL`, default 4: accepted beats per channel in scan mode, 1..255.
- `SW`, derived as `$clog2(N)`: select width. Not overridable.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mode`  in  1  0 = MANUAL, 1 = SCAN.
- `sel_in`  in  SW  channel to load.
- `sel_load`  in  1  single-cycle strobe that loads `sel_in`.
- `di`  in  N*W  channel k occupies bits `[k*W +: W]`.
- `di_valid`  in  N  per-channel valid.
- `y`  out  W  registered selected data.
- `y_valid`  out  1  `y` holds valid data.
- `y_ready`  in  1  downstream accepts the current `y`.
- `y_sel`  out  SW  channel index that `y` came from.
- `sel_err`  out  1  one-cycle pulse: `sel_in >= N` was loaded.

## Operation
- Internal state: `cur_sel` (SW bits) and `dwell_cnt` (8 bits). The FSM has two states, MANUAL and SCAN, and follows `mode` on every clock.
- Capture condition `cap = !y_valid || y_ready`. On `cap`:
  - `y <= di[cur_sel]`
  - `y_valid <= di_valid[cur_sel]`
  - `y_sel <= cur_sel`
- When `cap` is low, `y`, `y_valid` and `y_sel` hold.
- `sel_load` with `sel_in < N`: `cur_sel <= sel_in` and `dwell_cnt <= 0`. This applies in either mode.
- `sel_load` with `sel_in >= N`: `cur_sel` and `dwell_cnt` are unchanged, and `sel_err` is 1 for the next cycle.
- MANUAL: `cur_sel` changes only through `sel_load`. `dwell_cnt` is held at 0.
- SCAN, on `cap` with `di_valid[cur_sel] = 1`:
  - If `dwell_cnt == DWELL-1`: `cur_sel <= (cur_sel == N-1) ? 0 : cur_sel+1` and `dwell_cnt <= 0`.
  - Otherwise: `dwell_cnt++`.
- SCAN, on `cap` with `di_valid[cur_sel] = 0`: advance `cur_sel` immediately (same wrap rule) and set `dwell_cnt <= 0`. This beat does not consume dwell.
- Precedence on the same edge: `sel_load` wins over scan advance. A valid `sel_load` wins over a dwell expiry.
- Mode change:
  - MANUAL to SCAN: the scan starts at the current `cur_sel` with `dwell_cnt = 0`.
  - SCAN to MANUAL: `cur_sel` freezes and `dwell_cnt` clears.
- Out-of-range `cur_sel` is unreachable. Reset is 0 and every update is checked or wrapped.

## Timing
- Reset, asynchronous on `rst_n` low: `y=0`, `y_valid=0`, `y_sel=0`, `sel_err=0`, `cur_sel=0`, `dwell_cnt=0`, state MANUAL. The FSM follows `mode` from the first edge after release. Reset asserted mid-transfer drops `y_valid` immediately; there is no completion.
- Latency from data: one cycle. `di` sampled at edge t appears on `y` after edge t.
- Latency from select: two edges. A `sel_load` sampled at edge t updates `cur_sel` at t. The capture at t still uses the old channel. The new channel appears on `y` after edge t+1.
- Handshake: a transfer occurs on any edge with `y_valid && y_ready`.
  - While `y_valid && !y_ready`, `y`, `y_valid` and `y_sel` are stable, and scan/dwell does not advance.
  - A beat with `y_valid = 0` is overwritten on the next edge.
- Every output is registered. There is no combinational path from input to output.

## Structure
- Package `mux_pkg`:
  - mode encoding `MODE_MANUAL = 1'b0`, `MODE_SCAN = 1'b1`
  - FSM state enum `mux_state_t {ST_MANUAL, ST_SCAN}`
  - dwell counter width constant `DWELL_CW = 8`
- Sub-module `mux_nx1_comb`: a parametrised (`N`, `W`) purely combinational N:1 selector on the flat `di` bus. It is instantiated once, together with a 1-bit instance that selects `di_valid`. The top level contains only the FSM, the counters and the output register.

## Test plan
All scenarios use `N=16`, `W=8`, `DWELL=4`, with `di` channel k = `8'h10+k` and all `di_valid` = 1 unless stated otherwise.
1. Reset: assert `rst_n` low mid-scan with `y_valid = 1` -> `y=0`, `y_valid=0`, `y_sel=0` immediately, before the next edge. After release with `mode = 0` -> `y = 8'h10` and `y_sel = 0` after the first edge.
2. Manual: `sel_load` with `sel_in=5` at edge t, `y_ready=1` -> `y=8'h15`, `y_sel=5` after edge t+1. `y` is still `8'h10` after edge t.
3. Scan wrap: `sel_load` 14, then `mode=1`, `y_ready=1` -> `y_sel` sequence 14×4, 15×4, 0×4, with `y` values `8'h1E`, `8'h1F`, `8'h10`.
4. Backpressure: in scan mode, drop `y_ready` for 3 cycles during dwell beat 2 of channel 2 -> `y=8'h12`, `y_valid=1`, `y_sel=2` held for 3 cycles. Channel 2 still totals exactly 4 accepted beats.
5. Skip: in scan mode with `di_valid[3]=0` -> `y_sel=3` for exactly one beat with `y_valid=0`, then 4 beats with `y_sel=4`.
6. Select errors and precedence, with `N=12`:
   - `sel_load` with `sel_in=13` -> `sel_err` high for exactly one cycle, `y_sel` unchanged.
   - `sel_load` with `sel_in=7` on the same edge as dwell expiry of channel 2 -> the next channel is 7, not 3.
